// File: rtl/picomips_pkg.sv
// Shared picoMIPS constants, PC operation encoding and small sizing helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package picomips_pkg;

   // Program memory is 256 words in the base core.
   localparam int PROG_MEM_ADDR_WIDTH = 8;

   // PC update operation selected each enabled cycle.
   typedef enum logic [2:0] {
      PC_INC,
      PC_BRANCH,
      PC_CALL,
      PC_RET,
      PC_ILLEGAL
   } pc_op_t;

   // Priority decode of the decoder strobes.
   // call+ret together is rejected outright.
   // branch only matters when neither stack strobe is present.
   function automatic pc_op_t decode_pc_op(input logic call,
                                           input logic ret,
                                           input logic branch);
      if (call && ret) return PC_ILLEGAL;
      if (ret)         return PC_RET;
      if (call)        return PC_CALL;
      if (branch)      return PC_BRANCH;
      return PC_INC;
   endfunction

   // Stack pointer width: the pointer must be able to count 0..depth inclusive.
   function automatic int sp_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO held in a register array, with a 0..DEPTH stack pointer.
// Latency: push/pop take effect at the clock edge; dout shows the current top combinationally.
// Backpressure: push is dropped when full and pop is ignored when empty; full/empty report status.
module return_stack
   import picomips_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              din,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [sp_width(DEPTH)-1:0]    sp
);

   localparam int SPW = sp_width(DEPTH);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SPW-1:0]   sp_q;
   logic [SPW-1:0]   sp_m1;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic             do_push;
   logic             do_pop;

   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);
   assign sp    = sp_q;

   // Overflowing pushes and underflowing pops are dropped here.
   // The caller is responsible for flagging them.
   // If push and pop are both requested, push wins.
   // The PC block never requests both in the same cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~push & ~empty;

   // Slot sp is the next free entry; slot sp-1 is the current top.
   assign sp_m1  = sp_q - SPW'(1);
   assign wr_idx = sp_q[IW-1:0];
   assign rd_idx = sp_m1[IW-1:0];

   // Top-of-stack read; forced to zero when empty so no stale slot leaks out.
   assign dout = empty ? '0 : mem[rd_idx];

   // Entry storage: contents are don't-care after reset, so no reset is applied.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_idx] <= din;
      end
   end

   // Stack pointer: cleared by reset; moves by one on each accepted push or pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp_q <= '0;
      end else if (do_push) begin
         sp_q <= sp_q + SPW'(1);
      end else if (do_pop) begin
         sp_q <= sp_m1;
      end
   end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with absolute/relative branches and call/return through a hardware return stack.
// Latency: the new addr is visible one cycle after an enabled edge; stack flags follow the registered pointer.
// Backpressure: none; enable low freezes PC, stack and error flag; overflow/underflow set sticky stack_err.
module pc_call_stack
   import picomips_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = PROG_MEM_ADDR_WIDTH,
   parameter int                    STACK_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  branch,
   input  logic                  rel,
   input  logic                  call,
   input  logic                  ret,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  stack_full,
   output logic                  stack_empty,
   output logic                  stack_err
);

   localparam int SPW = sp_width(STACK_DEPTH);

   pc_op_t                op;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] next_seq;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  err_q;
   logic                  err_set;
   logic                  stk_push;
   logic                  stk_pop;
   logic [ADDR_WIDTH-1:0] stk_dout;
   logic                  stk_full;
   logic                  stk_empty;
   logic [SPW-1:0]        stk_sp;

   assign op = decode_pc_op(call, ret, branch);

   // The offset already has the full PC width.
   // Modular addition of a two's-complement value is therefore the signed add.
   // Carries fall off the top.
   assign next_seq = addr_q + ADDR_WIDTH'(1);
   assign target   = rel ? (addr_q + branch_addr) : branch_addr;

   // The stack itself drops an overflowing push or an underflowing pop.
   assign stk_push = enable & (op == PC_CALL);
   assign stk_pop  = enable & (op == PC_RET);

   return_stack #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_return_stack (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (stk_push),
      .pop     (stk_pop),
      .din     (next_seq),
      .dout    (stk_dout),
      .full    (stk_full),
      .empty   (stk_empty),
      .sp      (stk_sp)
   );

   // Next-PC select.
   // A failed return falls through sequentially.
   // An overflowing call still takes its jump.
   always_comb begin
      next_pc = next_seq;
      err_set = 1'b0;
      case (op)
         PC_ILLEGAL: begin
            next_pc = next_seq;
            err_set = 1'b1;
         end
         PC_RET: begin
            if (stk_empty) begin
               next_pc = next_seq;
               err_set = 1'b1;
            end else begin
               next_pc = stk_dout;
            end
         end
         PC_CALL: begin
            next_pc = target;
            err_set = stk_full;
         end
         PC_BRANCH: begin
            next_pc = target;
         end
         default: begin
            next_pc = next_seq;
         end
      endcase
   end

   // PC register and sticky error flag: only enabled edges change them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= RESET_ADDR;
         err_q  <= 1'b0;
      end else if (enable) begin
         addr_q <= next_pc;
         err_q  <= err_q | err_set;
      end
   end

   assign addr        = addr_q;
   assign stack_err   = err_q;
   assign stack_full  = (stk_sp == SPW'(STACK_DEPTH));
   assign stack_empty = (stk_sp == '0);

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised next-generation program counter for the picoMIPS-style core.
- Adds to plain increment/absolute-branch:
  - PC-relative branches.
  - Subroutine call/return through a hardware return-address stack (LIFO).
  - Stack full/empty status and a sticky error flag.
- Sits between the decoder, which drives control strobes during the decode cycle, and program memory, which is addressed by `addr`. All updates are qualified by `enable`.

Parameters:
- ADDR_WIDTH, 8, width of program-memory address and PC.
- STACK_DEPTH, 4, number of return-address entries (>=1; need not be a power of 2).
- RESET_ADDR, 0, value loaded into the PC on reset.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset; clears PC, stack pointer and error flag
- enable  input  1  PC/stack update strobe; no state changes when low
- branch  input  1  take branch to target
- rel  input  1  1: target = addr + signed branch_addr; 0: target = branch_addr
- call  input  1  take branch to target and push addr+1
- ret  input  1  pop top of stack into PC
- branch_addr  input  ADDR_WIDTH  absolute target or two's-complement offset
- addr  output  ADDR_WIDTH  current PC (registered)
- stack_full  output  1  stack pointer == STACK_DEPTH (combinational from the registered pointer)
- stack_empty  output  1  stack pointer == 0
- stack_err  output  1  sticky over/underflow or illegal-combination flag

Behaviour:
- Reset (reset_n low, asynchronous, overrides everything):
  - addr = RESET_ADDR, sp = 0, stack_err = 0.
  - Therefore stack_empty = 1 and stack_full = 0.
  - Stack contents are don't-care.
  - Release is sampled at the next rising clk edge.
- All state updates occur on the rising clk edge when enable = 1. The new addr is visible one cycle after the enabled edge.
- enable = 0: addr, sp, stack contents and stack_err hold regardless of other inputs.
- target = rel ? (addr + sign-extended branch_addr) : branch_addr.
  - Arithmetic is mod 2^ADDR_WIDTH; carries are discarded.
- next-sequential = addr + 1 mod 2^ADDR_WIDTH, so 2^W-1 wraps to 0.
- Operation select, evaluated per enabled edge in priority order:
  1. call & ret: illegal. PC <- next-sequential; stack unchanged; stack_err <- 1.
  2. ret:
     - Not empty: PC <- stack[sp-1]; sp <- sp-1.
     - Empty: PC <- next-sequential; sp stays 0; stack_err <- 1.
  3. call:
     - Not full: stack[sp] <- next-sequential; sp <- sp+1; PC <- target.
     - Full: PC <- target (jump still taken); push dropped; sp unchanged; stack_err <- 1.
  4. branch (with call = ret = 0): PC <- target; stack untouched.
  5. Otherwise: PC <- next-sequential.
- branch is ignored when call or ret is asserted. call implies the branch target and uses rel the same way.
- stack_err is sticky: once set, it stays set until reset_n is asserted.
- Nesting: DEPTH consecutive calls with no returns fill the stack exactly. The returns unwind in LIFO order.
- Reset mid-sequence discards all pending return addresses.

Decomposition:
- Shared constants package (picomips_pkg) holds:
  - PROG_MEM_ADDR_WIDTH, used as the default ADDR_WIDTH.
  - An operation enum pc_op_t {PC_INC, PC_BRANCH, PC_CALL, PC_RET, PC_ILLEGAL} used by the internal priority decoder and exported for the decoder and bench.
- One sub-module: return_stack.
  - Parametrised LIFO (WIDTH, DEPTH).
  - Ports: push, pop, din, dout, full, empty, sp; same clk/reset_n.
  - Register-array storage.
- Top level contains the op decoder, target adder, next-PC mux and the error flag.

Test Plan:
1. Reset, then 5 enabled cycles with no strobes -> addr 0,1,2,3,4,5; stack_empty=1; stack_err=0. Drop enable for 3 cycles -> addr holds 5.
2. At addr=10: branch, rel=1, branch_addr=8'hFD -> addr=7. At addr=250 (ADDR_WIDTH=8): rel=1, branch_addr=10 -> addr=4. At addr=255, no strobe -> addr=0.
3. At addr=20: call, absolute 100 -> addr=100, stack_empty=0. Then ret -> addr=21, stack_empty=1, stack_err=0.
4. DEPTH=4, calls from addrs 1, 11, 21, 31 to targets 10, 20, 30, 40 -> stack_full=1. Fifth call to 50 -> addr=50, stack_err=1, sp stays 4. Four rets -> addr 32, 22, 12, 2.
5. From reset: ret at addr=3 -> addr=4, stack_err=1. Then call+ret together at addr=4 -> addr=5, stack unchanged, stack_err stays 1.
6. Assert reset_n low mid-clock after two calls -> addr=RESET_ADDR immediately (before the next edge), stack_empty=1, stack_err=0. Then ret -> underflow flagged.
